// File: rtl/nmi_arb2_if.sv
// nmi_if: native memory interface bundle shared by CPU, DMA and the decode wrapper.
//   valid  master -> slave  request strobe, held until ready
//   addr   master -> slave  32-bit byte address
//   wdata  master -> slave  32-bit write data
//   wstrb  master -> slave  byte write strobes (0 = read)
//   ready  slave -> master  transaction completes this cycle
//   rdata  slave -> master  read data, valid with ready
interface nmi_if;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;

    modport master (output valid, output addr, output wdata, output wstrb,
                    input  ready, input  rdata);
    modport slave  (input  valid, input  addr, input  wdata, input  wstrb,
                    output ready, output rdata);
endinterface

// File: rtl/nmi_arb2.sv
// nmi_arb2: round-robin two-master NMI arbiter with bus-timeout watchdog.
// One whole transaction is granted at a time; an IDLE cycle separates grants.
// Ports:
//   clk_i       system clock
//   rst_i       synchronous active-high reset
//   m0          CPU request port (nmi_if.slave)
//   m1          DMA request port (nmi_if.slave)
//   s           merged port toward address decode (nmi_if.master)
//   err_o       one-cycle pulse on a timeout completion
//   err_addr_o  address of the most recent timed-out transaction
//   err_mst_o   master of the most recent timeout (0 = m0, 1 = m1)
module nmi_arb2 #(
    parameter int unsigned TIMEOUT_CYC = 1023,
    parameter logic [31:0] ERR_RDATA   = 32'hFFFF_FFFF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    nmi_if.slave        m0,
    nmi_if.slave        m1,
    nmi_if.master       s,
    output logic        err_o,
    output logic [31:0] err_addr_o,
    output logic        err_mst_o
);

    localparam bit          WDOG_EN = (TIMEOUT_CYC != 0);
    localparam int unsigned TW      = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TERM  = WDOG_EN ? TW'(TIMEOUT_CYC - 1) : '0;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic          grant_q, grant_d;
    logic          last_grant_q, last_grant_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [31:0]   err_addr_q, err_addr_d;
    logic          err_mst_q, err_mst_d;

    // Payload of the currently granted master.
    logic        sel_valid;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_wstrb;

    logic        done_c;
    logic [31:0] ret_rdata_c;

    assign sel_valid = grant_q ? m1.valid : m0.valid;
    assign sel_addr  = grant_q ? m1.addr  : m0.addr;
    assign sel_wdata = grant_q ? m1.wdata : m0.wdata;
    assign sel_wstrb = grant_q ? m1.wstrb : m0.wstrb;

    assign err_addr_o = err_addr_q;
    assign err_mst_o  = err_mst_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            tcnt_q       <= '0;
            err_addr_q   <= '0;
            err_mst_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            tcnt_q       <= tcnt_d;
            err_addr_q   <= err_addr_d;
            err_mst_q    <= err_mst_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        tcnt_d       = tcnt_q;
        err_addr_d   = err_addr_q;
        err_mst_d    = err_mst_q;
        done_c       = 1'b0;
        ret_rdata_c  = '0;
        err_o        = 1'b0;
        s.valid      = 1'b0;
        s.addr       = '0;
        s.wdata      = '0;
        s.wstrb      = '0;
        m0.ready     = 1'b0;
        m0.rdata     = '0;
        m1.ready     = 1'b0;
        m1.rdata     = '0;

        unique case (state_q)
            IDLE: begin
                tcnt_d = '0;
                if (m0.valid || m1.valid) begin
                    // Contention goes to whichever master was not served last.
                    grant_d = (m0.valid && m1.valid) ? ~last_grant_q : m1.valid;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                s.valid = sel_valid;
                s.addr  = sel_addr;
                s.wdata = sel_wdata;
                s.wstrb = sel_wstrb;
                // Priority: abort, then slave ready, then watchdog expiry.
                if (!sel_valid) begin
                    state_d = IDLE;
                end else if (s.ready) begin
                    done_c      = 1'b1;
                    ret_rdata_c = s.rdata;
                end else if (WDOG_EN && (tcnt_q == TERM)) begin
                    done_c      = 1'b1;
                    ret_rdata_c = ERR_RDATA;
                    err_o       = 1'b1;
                    err_addr_d  = sel_addr;
                    err_mst_d   = grant_q;
                end else if (WDOG_EN) begin
                    tcnt_d = tcnt_q + 1'b1;
                end

                if (done_c) begin
                    state_d      = IDLE;
                    last_grant_d = grant_q;
                    if (grant_q) begin
                        m1.ready = 1'b1;
                        m1.rdata = ret_rdata_c;
                    end else begin
                        m0.ready = 1'b1;
                        m0.rdata = ret_rdata_c;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_nmi_arb2.sv
// Directed self-checking bench for nmi_arb2 with a 16-cycle watchdog.
// Inputs change 1 time unit after the rising edge; outputs are checked 2 units
// later, well before the next edge.
module tb_nmi_arb2;

    localparam logic [31:0] A0 = 32'h0000_0040;
    localparam logic [31:0] A1 = 32'h1000_0300;

    logic clk;
    logic rst;
    logic err;
    logic [31:0] err_addr;
    logic err_mst;

    int nchecks = 0;
    int nerrs   = 0;

    nmi_if m0_bus ();
    nmi_if m1_bus ();
    nmi_if s_bus ();

    nmi_arb2 #(.TIMEOUT_CYC(16), .ERR_RDATA(32'hFFFF_FFFF)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .m0         (m0_bus),
        .m1         (m1_bus),
        .s          (s_bus),
        .err_o      (err),
        .err_addr_o (err_addr),
        .err_mst_o  (err_mst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrs++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        m0_bus.valid = 1'b0; m0_bus.addr = '0; m0_bus.wdata = '0; m0_bus.wstrb = '0;
        m1_bus.valid = 1'b0; m1_bus.addr = '0; m1_bus.wdata = '0; m1_bus.wstrb = '0;
        s_bus.ready = 1'b0;  s_bus.rdata = '0;
        tick(); tick();

        // Reset state
        settle();
        chk1("rst_svalid", s_bus.valid, 1'b0);
        chk1("rst_m0rdy", m0_bus.ready, 1'b0);
        chk1("rst_m1rdy", m1_bus.ready, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk32("rst_erraddr", err_addr, 32'h0);
        chk1("rst_errmst", err_mst, 1'b0);
        rst = 1'b0;
        tick();

        // T1: single m0 read, slave ready two cycles after s.valid
        m0_bus.valid = 1'b1; m0_bus.addr = A0;
        settle();
        chk1("t1_req_svalid", s_bus.valid, 1'b0);
        tick();
        settle();
        chk1("t1_b1_svalid", s_bus.valid, 1'b1);
        chk32("t1_b1_saddr", s_bus.addr, A0);
        chk1("t1_b1_m0rdy", m0_bus.ready, 1'b0);
        tick();
        settle();
        chk1("t1_b2_m0rdy", m0_bus.ready, 1'b0);
        tick();
        s_bus.ready = 1'b1; s_bus.rdata = 32'h1234_5678;
        settle();
        chk1("t1_m0rdy", m0_bus.ready, 1'b1);
        chk32("t1_m0rdata", m0_bus.rdata, 32'h1234_5678);
        chk1("t1_m1rdy", m1_bus.ready, 1'b0);
        chk1("t1_err", err, 1'b0);
        tick();
        m0_bus.valid = 1'b0; s_bus.ready = 1'b0;
        settle();
        chk1("t1_idle_svalid", s_bus.valid, 1'b0);
        tick();

        // T2: both valid from reset, zero-wait slave, alternating grants
        rst = 1'b1;
        m0_bus.valid = 1'b1; m0_bus.addr = A0;
        m1_bus.valid = 1'b1; m1_bus.addr = A1;
        tick();
        rst = 1'b0;
        s_bus.ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            settle();
            chk1("t2_idle_svalid", s_bus.valid, 1'b0);
            chk1("t2_idle_m0rdy", m0_bus.ready, 1'b0);
            chk1("t2_idle_m1rdy", m1_bus.ready, 1'b0);
            tick();
            s_bus.rdata = 32'hA5A5_0000 | 32'(k);
            settle();
            chk1("t2_busy_svalid", s_bus.valid, 1'b1);
            chk32("t2_busy_saddr", s_bus.addr, (k % 2 == 1) ? A1 : A0);
            chk1("t2_busy_m0rdy", m0_bus.ready, (k % 2 == 0));
            chk1("t2_busy_m1rdy", m1_bus.ready, (k % 2 == 1));
            if (k % 2 == 1) begin
                chk32("t2_m1rdata", m1_bus.rdata, 32'hA5A5_0000 | 32'(k));
                chk32("t2_m0rdata_idle", m0_bus.rdata, 32'h0);
            end else begin
                chk32("t2_m0rdata", m0_bus.rdata, 32'hA5A5_0000 | 32'(k));
                chk32("t2_m1rdata_idle", m1_bus.rdata, 32'h0);
            end
            tick();
        end
        m0_bus.valid = 1'b0; m1_bus.valid = 1'b0; s_bus.ready = 1'b0; s_bus.rdata = '0;
        settle();
        chk1("t2_end_svalid", s_bus.valid, 1'b0);
        tick();

        // T3: m1 write to a dead slave, watchdog fires on BUSY cycle 16
        m1_bus.valid = 1'b1; m1_bus.addr = A1; m1_bus.wdata = 32'hDEAD_BEEF; m1_bus.wstrb = 4'b0011;
        settle();
        chk1("t3_req_svalid", s_bus.valid, 1'b0);
        tick();
        for (int b = 1; b <= 16; b++) begin
            settle();
            if (b == 1) begin
                chk32("t3_saddr", s_bus.addr, A1);
                chk32("t3_swdata", s_bus.wdata, 32'hDEAD_BEEF);
                chk32("t3_swstrb", 32'(s_bus.wstrb), 32'h3);
            end
            if (b < 16) begin
                chk1("t3_wait_m1rdy", m1_bus.ready, 1'b0);
                chk1("t3_wait_err", err, 1'b0);
            end else begin
                chk1("t3_to_m1rdy", m1_bus.ready, 1'b1);
                chk1("t3_to_err", err, 1'b1);
                chk32("t3_to_rdata", m1_bus.rdata, 32'hFFFF_FFFF);
                chk1("t3_to_m0rdy", m0_bus.ready, 1'b0);
            end
            tick();
        end
        m1_bus.valid = 1'b0;
        settle();
        chk1("t3_after_err", err, 1'b0);
        chk32("t3_erraddr", err_addr, A1);
        chk1("t3_errmst", err_mst, 1'b1);
        chk1("t3_after_svalid", s_bus.valid, 1'b0);
        tick();

        // T4: slave ready exactly on the terminal cycle -> normal completion
        m0_bus.valid = 1'b1; m0_bus.addr = A0; m0_bus.wstrb = 4'b0000;
        settle();
        tick();
        for (int b = 1; b <= 16; b++) begin
            if (b == 16) begin
                s_bus.ready = 1'b1; s_bus.rdata = 32'hCAFE_F00D;
            end
            settle();
            if (b < 16) begin
                chk1("t4_wait_m0rdy", m0_bus.ready, 1'b0);
            end else begin
                chk1("t4_m0rdy", m0_bus.ready, 1'b1);
                chk32("t4_m0rdata", m0_bus.rdata, 32'hCAFE_F00D);
                chk1("t4_err", err, 1'b0);
            end
            tick();
        end
        m0_bus.valid = 1'b0; s_bus.ready = 1'b0; s_bus.rdata = '0;
        settle();
        chk1("t4_after_err", err, 1'b0);
        chk32("t4_erraddr_kept", err_addr, A1);
        chk1("t4_errmst_kept", err_mst, 1'b1);
        tick();

        // T5: granted m0 aborts on BUSY cycle 2, pending m1 follows
        m0_bus.valid = 1'b1; m0_bus.addr = A0;
        settle();
        chk1("t5_req_svalid", s_bus.valid, 1'b0);
        tick();
        m1_bus.valid = 1'b1; m1_bus.addr = A1;
        settle();
        chk1("t5_b1_svalid", s_bus.valid, 1'b1);
        chk32("t5_b1_saddr", s_bus.addr, A0);
        chk1("t5_b1_m1rdy", m1_bus.ready, 1'b0);
        tick();
        m0_bus.valid = 1'b0;
        settle();
        chk1("t5_abort_svalid", s_bus.valid, 1'b0);
        chk1("t5_abort_m0rdy", m0_bus.ready, 1'b0);
        chk1("t5_abort_err", err, 1'b0);
        tick();
        settle();
        chk1("t5_idle_svalid", s_bus.valid, 1'b0);
        chk1("t5_idle_m1rdy", m1_bus.ready, 1'b0);
        tick();
        settle();
        chk1("t5_m1_svalid", s_bus.valid, 1'b1);
        chk32("t5_m1_saddr", s_bus.addr, A1);

        // T6: reset during the m1 transaction, then contention goes to m0
        rst = 1'b1;
        m0_bus.valid = 1'b1;
        tick();
        settle();
        chk1("t6_svalid", s_bus.valid, 1'b0);
        chk1("t6_m0rdy", m0_bus.ready, 1'b0);
        chk1("t6_m1rdy", m1_bus.ready, 1'b0);
        chk1("t6_err", err, 1'b0);
        chk32("t6_erraddr", err_addr, 32'h0);
        chk1("t6_errmst", err_mst, 1'b0);
        rst = 1'b0;
        tick();
        settle();
        chk1("t6_grant_svalid", s_bus.valid, 1'b1);
        chk32("t6_grant_saddr", s_bus.addr, A0);
        chk1("t6_grant_m1rdy", m1_bus.ready, 1'b0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end

endmodule
